// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - multi-cycle data memory with programmable wait states and req/ready handshake
// Optional misaligned-word rejection: define DMEM_ALIGN_CHK_EN.
module dmem_wait_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic        sb,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           lat_write;
  logic           lat_sb;
  logic [AW+1:0]  lat_adr;
  logic [31:0]    lat_data;

  logic [31:0]    mem [DEPTH];

  // Fields of the access about to enter RESP: straight from the bus when
  // leaving IDLE with no wait states, otherwise the latched copy.
  logic           acc_write;
  logic           acc_sb;
  logic [AW+1:0]  acc_adr;
  logic [AW-1:0]  acc_idx;
  logic [1:0]     acc_lane;
  logic [31:0]    acc_word;
  logic [7:0]     acc_byte;
  logic           acc_mis;
  logic [31:0]    rd_next;

  logic [AW-1:0]  lat_idx;
  logic [1:0]     lat_lane;
  logic           lat_mis;
  logic           we;

  logic           unused_bits;
  assign unused_bits = ^dataadr[31:AW+2];

  assign acc_write = (state == S_IDLE) ? memwrite : lat_write;
  assign acc_sb    = (state == S_IDLE) ? sb : lat_sb;
  assign acc_adr   = (state == S_IDLE) ? dataadr[AW+1:0] : lat_adr;
  assign acc_idx   = acc_adr[AW+1:2];
  assign acc_lane  = acc_adr[1:0];
  assign acc_word  = mem[acc_idx];
  assign acc_byte  = acc_word[{acc_lane, 3'b000} +: 8];

  assign lat_idx   = lat_adr[AW+1:2];
  assign lat_lane  = lat_adr[1:0];

`ifdef DMEM_ALIGN_CHK_EN
  assign acc_mis = ~acc_sb & (acc_lane != 2'b00);
  assign lat_mis = ~lat_sb & (lat_lane != 2'b00);
`else
  assign acc_mis = 1'b0;
  assign lat_mis = 1'b0;
`endif

  always_comb begin
    rd_next = 32'h0;
    if (!acc_write && !acc_mis) begin
      rd_next = acc_sb ? {24'h0, acc_byte} : acc_word;
    end
  end

  assign stall = req & ~ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      readdata  <= 32'h0;
      err       <= 1'b0;
      lat_write <= 1'b0;
      lat_sb    <= 1'b0;
      lat_adr   <= '0;
      lat_data  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          ready    <= 1'b0;
          readdata <= 32'h0;
          err      <= 1'b0;
          if (req) begin
            lat_write <= memwrite;
            lat_sb    <= sb;
            lat_adr   <= dataadr[AW+1:0];
            lat_data  <= writedata;
            cnt       <= CW'(WAIT_CYCLES);
            if (WAIT_CYCLES > 0) begin
              state <= S_WAIT;
            end else begin
              state    <= S_RESP;
              ready    <= 1'b1;
              readdata <= rd_next;
              err      <= acc_mis;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= S_RESP;
            ready    <= 1'b1;
            readdata <= rd_next;
            err      <= acc_mis;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          ready    <= 1'b0;
          readdata <= 32'h0;
          err      <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          ready    <= 1'b0;
          readdata <= 32'h0;
          err      <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never reset; a reset at the RESP edge suppresses the commit.
  assign we = (state == S_RESP) & lat_write & ~lat_mis & ~reset;

  always_ff @(posedge clk) begin
    if (we) begin
      if (lat_sb) begin
        mem[lat_idx][{lat_lane, 3'b000} +: 8] <= lat_data[7:0];
      end else begin
        mem[lat_idx] <= lat_data;
      end
    end
  end

endmodule
